al422_frame_writer: RTL and testbench

- Upstream stage of al422_bam_bs: fills the AL422 FIFO write port with one complete frame image that al422_bam_bs later reads back.
- Each frame is a fixed 8-byte header followed by PIX_BYTES pixel bytes taken from a valid/ready byte stream (host link).
- Generates the write-reset pulse, the active-low write enable and the data bus. Clocked by the same in_clk that drives AL422 WCK.

---
 rtl/al422_frame_writer.sv | 165 ++++++++++++++++
 tb/tb_al422_frame_writer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/al422_frame_writer.sv
// Writes one frame image into the AL422 FIFO: a write-reset pulse, an 8-byte header, then
// PIX_BYTES pixel bytes taken from a valid/ready byte stream. Every output is registered.
module al422_frame_writer #(
    parameter int PIX_BYTES   = 6144,
    parameter int WRST_CYCLES = 4
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  cfg_byte,
    input  logic [15:0] t_active,
    input  logic [15:0] t_inactive,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        al422_wrst_n,
    output logic        al422_we_n,
    output logic [7:0]  al422_d,
    output logic        busy,
    output logic        frame_done
);
    typedef enum logic [2:0] {IDLE, WRST, HDR, PIX, DONE} state_t;

    localparam logic [3:0]  WRST_LAST = 4'(WRST_CYCLES - 1);
    localparam logic [15:0] PIX_LAST  = 16'(PIX_BYTES - 1);

    state_t      state, state_n;
    logic [3:0]  wcnt, wcnt_n;
    logic [3:0]  hidx, hidx_n;
    logic [15:0] pcnt, pcnt_n;
    logic        wrst_n_n, we_n_n, ready_n, busy_n, done_n;
    logic [7:0]  d_n;
    logic        latch;
    logic [7:0]  cfg_q;
    logic [15:0] ta_q, ti_q;

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [7:0] cfg,
                                            input logic [15:0] ta, input logic [15:0] ti);
        logic [7:0] b;
        case (idx)
            3'd0:    b = cfg;
            3'd1:    b = ta[7:0];
            3'd2:    b = ta[15:8];
            3'd6:    b = ti[7:0];
            3'd7:    b = ti[15:8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next-state logic also produces the next value of every registered output.
    always_comb begin
        state_n  = state;
        wcnt_n   = wcnt;
        hidx_n   = hidx;
        pcnt_n   = pcnt;
        wrst_n_n = 1'b1;
        we_n_n   = 1'b1;
        d_n      = al422_d;
        ready_n  = 1'b0;
        busy_n   = busy;
        done_n   = 1'b0;
        latch    = 1'b0;
        if (abort) begin
            state_n = IDLE;
            wcnt_n  = 4'd0;
            hidx_n  = 4'd0;
            pcnt_n  = 16'd0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy_n = 1'b0;
                    if (start) begin
                        latch    = 1'b1;
                        state_n  = WRST;
                        wcnt_n   = 4'd0;
                        wrst_n_n = 1'b0;
                        busy_n   = 1'b1;
                    end
                end
                WRST: begin
                    if (wcnt == WRST_LAST) begin
                        state_n = HDR;
                        wcnt_n  = 4'd0;
                        we_n_n  = 1'b0;
                        d_n     = cfg_q;
                        hidx_n  = 4'd1;
                    end else begin
                        wcnt_n   = wcnt + 4'd1;
                        wrst_n_n = 1'b0;
                    end
                end
                HDR: begin
                    // hidx runs one ahead of the byte currently on the bus.
                    if (hidx == 4'd8) begin
                        state_n = PIX;
                        hidx_n  = 4'd0;
                        pcnt_n  = 16'd0;
                        ready_n = 1'b1;
                    end else begin
                        d_n    = hdr_byte(hidx[2:0], cfg_q, ta_q, ti_q);
                        we_n_n = 1'b0;
                        hidx_n = hidx + 4'd1;
                    end
                end
                PIX: begin
                    ready_n = 1'b1;
                    if (s_valid && s_ready) begin
                        d_n    = s_data;
                        we_n_n = 1'b0;
                        pcnt_n = pcnt + 16'd1;
                        if (pcnt == PIX_LAST) begin
                            state_n = DONE;
                            pcnt_n  = 16'd0;
                            ready_n = 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state        <= IDLE;
            wcnt         <= 4'd0;
            hidx         <= 4'd0;
            pcnt         <= 16'd0;
            al422_wrst_n <= 1'b1;
            al422_we_n   <= 1'b1;
            al422_d      <= 8'h00;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_n;
            wcnt         <= wcnt_n;
            hidx         <= hidx_n;
            pcnt         <= pcnt_n;
            al422_wrst_n <= wrst_n_n;
            al422_we_n   <= we_n_n;
            al422_d      <= d_n;
            s_ready      <= ready_n;
            busy         <= busy_n;
            frame_done   <= done_n;
        end
    end

    // Header fields are frozen when the frame is accepted.
    always_ff @(posedge in_clk) begin
        if (latch) begin
            cfg_q <= cfg_byte;
            ta_q  <= t_active;
            ti_q  <= t_inactive;
        end
    end
endmodule

// File: tb/tb_al422_frame_writer.sv
// Directed bench for al422_frame_writer with PIX_BYTES=16, WRST_CYCLES=4.
module tb_al422_frame_writer;
    logic        in_clk, in_rst, start, abort;
    logic [7:0]  cfg_byte, s_data;
    logic [15:0] t_active, t_inactive;
    logic        s_valid, s_ready, al422_wrst_n, al422_we_n, busy, frame_done;
    logic [7:0]  al422_d;

    int n_checks = 0;
    int n_fail   = 0;

    int         wr_cnt, wrst_low, wrst_pulses, done_cnt, done_busy_bad, done_wr_at;
    int         mirror_bad, ready_hi;
    logic [7:0] wr_log [0:63];
    logic       prev_wrst, prev_rdy, prev_vld;

    al422_frame_writer #(.PIX_BYTES(16), .WRST_CYCLES(4)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .start(start), .abort(abort),
        .cfg_byte(cfg_byte), .t_active(t_active), .t_inactive(t_inactive),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .al422_wrst_n(al422_wrst_n), .al422_we_n(al422_we_n), .al422_d(al422_d),
        .busy(busy), .frame_done(frame_done)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Mid-cycle observer: records what the AL422 would capture on the next rising edge.
    always @(negedge in_clk) begin
        if (al422_we_n === 1'b0) begin
            if (wr_cnt < 64) wr_log[wr_cnt] = al422_d;
            wr_cnt++;
        end
        if (al422_wrst_n === 1'b0) begin
            wrst_low++;
            if (prev_wrst) wrst_pulses++;
        end
        prev_wrst = al422_wrst_n;
        if (frame_done === 1'b1) begin
            done_cnt++;
            if (busy !== 1'b0) done_busy_bad++;
            done_wr_at = wr_cnt;
        end
        if (prev_rdy && (al422_we_n !== !(prev_vld && prev_rdy))) mirror_bad++;
        if (s_ready === 1'b1) ready_hi++;
        prev_rdy = s_ready;
        prev_vld = s_valid;
    end

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic clr_mon();
        wr_cnt = 0; wrst_low = 0; wrst_pulses = 0; done_cnt = 0; done_busy_bad = 0;
        done_wr_at = 0; mirror_bad = 0; ready_hi = 0;
        prev_wrst = 1'b1; prev_rdy = 1'b0; prev_vld = 1'b0;
    endtask

    function automatic logic [7:0] exp_b(input int i);
        logic [7:0] hdr [0:7];
        hdr = '{8'h2F, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00};
        if (i < 8) return hdr[i];
        return 8'(i - 8);
    endfunction

    // One frame of stimulus: header fields 2F/0003/0005, pixels 00..0F.
    task automatic do_frame(input bit toggle, input bit chg_cfg, input bit restart,
                            input bit abort10, output bit timed_out);
        int  idx = 0;
        int  cyc = 0;
        bit  hs;
        bit  restarted = 0;
        bit  aborted = 0;
        timed_out = 0;
        clr_mon();
        cfg_byte = 8'h2F; t_active = 16'h0003; t_inactive = 16'h0005;
        start = 1'b1;
        step();
        start = 1'b0;
        if (chg_cfg) begin
            cfg_byte = 8'h05; t_active = 16'hFFFF; t_inactive = 16'hEEEE;
        end
        s_data = 8'h00;
        s_valid = 1'b1;
        while (idx < 16 && cyc < 400 && !aborted) begin
            @(negedge in_clk);
            hs = s_valid && s_ready;
            if (abort10 && hs && idx == 9) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                aborted = 1;
            end else begin
                step();
                cyc++;
                if (hs) begin
                    idx++;
                    s_data = 8'(idx);
                end
                if (restart && !restarted && idx == 5) begin
                    start = 1'b1;
                    restarted = 1;
                end else begin
                    start = 1'b0;
                end
                if (toggle) s_valid = ~s_valid;
            end
        end
        s_valid = 1'b0;
        start = 1'b0;
        if (cyc >= 400) timed_out = 1;
        if (!aborted) begin
            for (int k = 0; k < 50 && done_cnt == 0; k++) step();
            if (done_cnt == 0) timed_out = 1;
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        in_rst = 1'b1;
        step(); step();
        n_checks++; if (al422_wrst_n !== 1'b1) begin n_fail++; $display("FAIL rst_wrst_n got=%b want=1", al422_wrst_n); end
        n_checks++; if (al422_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_we_n got=%b want=1", al422_we_n); end
        n_checks++; if (al422_d !== 8'h00) begin n_fail++; $display("FAIL rst_d got=%h want=00", al422_d); end
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got=%b want=0", frame_done); end
        in_rst = 1'b0;
        step();
    endtask

    task automatic check_full(input string tag, input bit to);
        n_checks++; if (to) begin n_fail++; $display("FAIL %s_timeout got=1 want=0", tag); end
        n_checks++; if (wrst_low != 4) begin n_fail++; $display("FAIL %s_wrst_low got=%0d want=4", tag, wrst_low); end
        n_checks++; if (wrst_pulses != 1) begin n_fail++; $display("FAIL %s_wrst_pulses got=%0d want=1", tag, wrst_pulses); end
        n_checks++; if (wr_cnt != 24) begin n_fail++; $display("FAIL %s_writes got=%0d want=24", tag, wr_cnt); end
        for (int i = 0; i < 24; i++) begin
            n_checks++;
            if (wr_log[i] !== exp_b(i)) begin
                n_fail++; $display("FAIL %s_byte%0d got=%h want=%h", tag, i, wr_log[i], exp_b(i));
            end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_pulses got=%0d want=1", tag, done_cnt); end
        n_checks++; if (done_busy_bad != 0) begin n_fail++; $display("FAIL %s_done_busy got=%0d want=0", tag, done_busy_bad); end
        n_checks++; if (done_wr_at != 24) begin n_fail++; $display("FAIL %s_done_after_writes got=%0d want=24", tag, done_wr_at); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after got=%b want=0", tag, busy); end
    endtask

    task automatic test_basic_frame();
        bit to;
        do_frame(0, 0, 0, 0, to);
        check_full("basic", to);
    endtask

    task automatic test_valid_toggle();
        bit to;
        do_frame(1, 0, 0, 0, to);
        check_full("toggle", to);
        n_checks++; if (mirror_bad != 0) begin n_fail++; $display("FAIL toggle_we_mirror got=%0d want=0", mirror_bad); end
    endtask

    task automatic test_cfg_change();
        bit to;
        do_frame(0, 1, 0, 0, to);
        check_full("cfgchg", to);
    endtask

    task automatic test_restart_ignored();
        bit to;
        do_frame(0, 0, 1, 0, to);
        check_full("restart", to);
    endtask

    task automatic test_abort();
        bit to;
        do_frame(0, 0, 0, 1, to);
        n_checks++; if (wr_cnt != 17) begin n_fail++; $display("FAIL abort_writes got=%0d want=17", wr_cnt); end
        for (int i = 0; i < 17; i++) begin
            n_checks++;
            if (wr_log[i] !== exp_b(i)) begin
                n_fail++; $display("FAIL abort_byte%0d got=%h want=%h", i, wr_log[i], exp_b(i));
            end
        end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", busy); end
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL abort_s_ready got=%b want=0", s_ready); end
        do_frame(0, 0, 0, 0, to);
        check_full("after_abort", to);
    endtask

    task automatic test_reset_in_hdr();
        bit found = 0;
        bit to;
        clr_mon();
        cfg_byte = 8'h2F; t_active = 16'h0003; t_inactive = 16'h0005;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (al422_we_n === 1'b0) found = 1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL hdr_reached got=0 want=1"); end
        step();
        in_rst = 1'b1;
        #1;
        n_checks++; if (al422_we_n !== 1'b1) begin n_fail++; $display("FAIL hrst_we_n got=%b want=1", al422_we_n); end
        n_checks++; if (al422_d !== 8'h00) begin n_fail++; $display("FAIL hrst_d got=%h want=00", al422_d); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hrst_busy got=%b want=0", busy); end
        n_checks++; if (al422_wrst_n !== 1'b1) begin n_fail++; $display("FAIL hrst_wrst_n got=%b want=1", al422_wrst_n); end
        step(); step();
        in_rst = 1'b0;
        clr_mon();
        s_valid = 1'b1;
        s_data = 8'hAA;
        repeat (10) step();
        s_valid = 1'b0;
        n_checks++; if (ready_hi != 0) begin n_fail++; $display("FAIL idle_s_ready got=%0d want=0", ready_hi); end
        n_checks++; if (wr_cnt != 0) begin n_fail++; $display("FAIL idle_writes got=%0d want=0", wr_cnt); end
        do_frame(0, 0, 0, 0, to);
        check_full("after_rst", to);
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        cfg_byte = 8'h00; t_active = 16'h0000; t_inactive = 16'h0000;
        clr_mon();
        test_reset();
        test_basic_frame();
        test_valid_toggle();
        test_cfg_change();
        test_restart_ignored();
        test_abort();
        test_reset_in_hdr();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
